// File: rtl/bin2dig_pkg.sv
// Shared types, constants and the per-column BCD adjust rule
// for the binary-to-digit converter.
package bin2dig_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_W        = 4;
    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ_ADD    = 3;

    function automatic logic [DIGIT_W-1:0] bcd_adj(input logic [DIGIT_W-1:0] col);
        return (col >= DIGIT_W'(BCD_ADJ_THRESH)) ? col + DIGIT_W'(BCD_ADJ_ADD) : col;
    endfunction

endpackage

// File: rtl/bcd_adj_col.sv
// One double-dabble column: adds 3 when the digit is 5 or more, so the
// following left shift carries correctly into the next decimal column.
module bcd_adj_col
    import bin2dig_pkg::*;
(
    input  logic [DIGIT_W-1:0] col_in,
    output logic [DIGIT_W-1:0] col_out
);

    assign col_out = bcd_adj(col_in);

endmodule

// File: rtl/bin_to_digits.sv
// Handshaked binary-to-digit converter (hex split or serial double-dabble BCD).
// Optional leading-zero blank mask output enabled by defining BIN2DIG_BLANK_EN.
//
// state | meaning
// IDLE  | ready for a request; in_ready=1
// CONV  | BCD shifting, one input bit per cycle for IN_W cycles
// DONE  | result registered on the exit edge; out_valid pulses the next cycle
module bin_to_digits
    import bin2dig_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_W-1:0]           in_data,
    input  logic                      in_bcd,
    output logic                      busy,
    output logic                      out_valid,
    output logic [DIGIT_W*DIGITS-1:0] out_digits,
`ifdef BIN2DIG_BLANK_EN
    output logic [DIGITS-1:0]         blank_mask,
`endif
    output logic                      overflow
);

    localparam int CNT_W = $clog2(IN_W);
    localparam int COL_W = DIGIT_W * (DIGITS + 1);
    localparam int OUT_W = DIGIT_W * DIGITS;
    localparam int EXT_W = (IN_W > OUT_W) ? IN_W : OUT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [IN_W-1:0]    bin_sr;
    logic [COL_W-1:0]   col;
    logic [COL_W-1:0]   adj;
    logic [COL_W-1:0]   col_shift;
    logic               carry_acc;
    logic               mode_bcd;
    logic               load;
    logic               step;
    logic               finish;
    logic [EXT_W-1:0]   data_ext;
    logic [OUT_W-1:0]   res_digits;
    logic               res_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = in_bcd ? CONV : DONE;
                end
            end
            CONV: begin
                step = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    for (genvar g = 0; g < DIGITS + 1; g++) begin : g_col
        bcd_adj_col u_adj (
            .col_in  (col[DIGIT_W*g +: DIGIT_W]),
            .col_out (adj[DIGIT_W*g +: DIGIT_W])
        );
    end

    assign col_shift = {adj[COL_W-2:0], bin_sr[IN_W-1]};

    // Hex mode reuses the untouched capture register; zero-extend so narrow
    // inputs fill the upper digits with zeros.
    assign data_ext = EXT_W'(bin_sr);

    always_comb begin
        res_digits = '0;
        res_ovf    = 1'b0;
        if (mode_bcd) begin
            res_digits = col[OUT_W-1:0];
            res_ovf    = carry_acc | (|col[COL_W-1 -: DIGIT_W]);
        end else begin
            res_digits = data_ext[OUT_W-1:0];
            res_ovf    = |(data_ext >> OUT_W);
        end
    end

`ifdef BIN2DIG_BLANK_EN
    logic [DIGITS-1:0] res_blank;
    logic              zero_run;

    always_comb begin
        res_blank = '0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run & (res_digits[DIGIT_W*i +: DIGIT_W] == '0);
            res_blank[i] = zero_run;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            bin_sr     <= '0;
            col        <= '0;
            carry_acc  <= 1'b0;
            mode_bcd   <= 1'b0;
            out_valid  <= 1'b0;
            out_digits <= '0;
            overflow   <= 1'b0;
`ifdef BIN2DIG_BLANK_EN
            blank_mask <= '0;
`endif
        end else begin
            out_valid <= finish;
            if (load) begin
                bin_sr    <= in_data;
                mode_bcd  <= in_bcd;
                col       <= '0;
                carry_acc <= 1'b0;
                cnt       <= '0;
            end
            if (step) begin
                bin_sr    <= bin_sr << 1;
                col       <= col_shift;
                carry_acc <= carry_acc | adj[COL_W-1];
                cnt       <= cnt + CNT_W'(1);
            end
            if (finish) begin
                out_digits <= res_digits;
                overflow   <= res_ovf;
`ifdef BIN2DIG_BLANK_EN
                blank_mask <= res_blank;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bin_to_digits.sv
// Scoreboard bench for bin_to_digits: a 5-digit and a 3-digit instance,
// expected results queued at accept and compared against captured outputs.
module tb_bin_to_digits;

    typedef struct {
        logic [19:0] digits;
        logic        ovf;
        int          cyc;
        logic [4:0]  blank;
    } rec_t;

    localparam int LAT_BCD = 17;
    localparam int LAT_HEX = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_bcd, in_ready, busy, out_valid, overflow;
    logic [15:0] in_data;
    logic [19:0] out_digits;
    logic [4:0]  blank5;

    logic        in_valid3, in_bcd3, in_ready3, busy3, out_valid3, overflow3;
    logic [15:0] in_data3;
    logic [11:0] out_digits3;
    logic [2:0]  blank3;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    rec_t exp5[$];
    rec_t obs5[$];
    rec_t exp3[$];
    rec_t obs3[$];

    bin_to_digits #(.IN_W(16), .DIGITS(5)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_bcd     (in_bcd),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_digits (out_digits),
`ifdef BIN2DIG_BLANK_EN
        .blank_mask (blank5),
`endif
        .overflow   (overflow)
    );

    bin_to_digits #(.IN_W(16), .DIGITS(3)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid3),
        .in_ready   (in_ready3),
        .in_data    (in_data3),
        .in_bcd     (in_bcd3),
        .busy       (busy3),
        .out_valid  (out_valid3),
        .out_digits (out_digits3),
`ifdef BIN2DIG_BLANK_EN
        .blank_mask (blank3),
`endif
        .overflow   (overflow3)
    );

`ifndef BIN2DIG_BLANK_EN
    assign blank5 = '0;
    assign blank3 = '0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1)
            obs5.push_back('{digits: out_digits, ovf: overflow, cyc: cyc, blank: blank5});
        if (out_valid3 === 1'b1)
            obs3.push_back('{digits: {8'h00, out_digits3}, ovf: overflow3, cyc: cyc, blank: {2'b00, blank3}});
    end

    function automatic logic [19:0] dec_model(input int v, input int nd);
        logic [19:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            if (i < nd) r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic dec_ovf(input int v, input int nd);
        int lim;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        return v >= lim;
    endfunction

    task automatic send5(input logic [15:0] d, input logic b, output int acc);
        acc = -1;
        in_valid = 1'b1;
        in_data  = d;
        in_bcd   = b;
        for (int i = 0; i < 100 && acc < 0; i++) begin
            if (in_ready === 1'b1) acc = cyc + 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send3(input logic [15:0] d, input logic b, output int acc);
        acc = -1;
        in_valid3 = 1'b1;
        in_data3  = d;
        in_bcd3   = b;
        for (int i = 0; i < 100 && acc < 0; i++) begin
            if (in_ready3 === 1'b1) acc = cyc + 1;
            @(negedge clk);
        end
        in_valid3 = 1'b0;
    endtask

    task automatic settle5(input int n);
        for (int i = 0; i < 400 && obs5.size() < n; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic settle3(input int n);
        for (int i = 0; i < 400 && obs3.size() < n; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, busy, out_valid, overflow, out_digits} !== {1'b1, 1'b0, 1'b0, 1'b0, 20'h0}) begin
            errors++;
            $display("FAIL reset5 got ready=%b busy=%b ov=%b ovf=%b dig=%h expected 1 0 0 0 00000",
                     in_ready, busy, out_valid, overflow, out_digits);
        end
        checks++;
        if ({in_ready3, busy3, out_valid3, overflow3, out_digits3} !== {1'b1, 1'b0, 1'b0, 1'b0, 12'h0}) begin
            errors++;
            $display("FAIL reset3 got ready=%b busy=%b ov=%b ovf=%b dig=%h expected 1 0 0 0 000",
                     in_ready3, busy3, out_valid3, overflow3, out_digits3);
        end
        checks++;
        if (blank5 !== 5'b0) begin
            errors++;
            $display("FAIL reset_blank got %b expected 00000", blank5);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bcd;
        logic [15:0] vals[12];
        int acc;
        rec_t e, o;
        vals = '{16'hFFFF, 16'd0, 16'd12345, 16'd1, 16'd9, 16'd10, 16'd9999, 16'd10000,
                 16'h0, 16'h0, 16'h0, 16'h0};
        for (int i = 8; i < 12; i++) vals[i] = 16'($urandom_range(0, 65535));
        for (int i = 0; i < 12; i++) begin
            send5(vals[i], 1'b1, acc);
            exp5.push_back('{digits: dec_model(int'(vals[i]), 5), ovf: 1'b0, cyc: acc + LAT_BCD, blank: 5'b0});
            if (i == 0) begin
                checks++;
                if (busy !== 1'b1 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bcd_busy got busy=%b ready=%b expected 1 0", busy, in_ready);
                end
            end
        end
        settle5(12);
        checks++;
        if (obs5.size() != exp5.size()) begin
            errors++;
            $display("FAIL bcd_count got %0d results expected %0d", obs5.size(), exp5.size());
        end
        while (exp5.size() > 0 && obs5.size() > 0) begin
            e = exp5.pop_front();
            o = obs5.pop_front();
            checks++;
            if (o.digits !== e.digits || o.ovf !== e.ovf || o.cyc !== e.cyc) begin
                errors++;
                $display("FAIL bcd_result got dig=%h ovf=%b cyc=%0d expected dig=%h ovf=%b cyc=%0d",
                         o.digits, o.ovf, o.cyc, e.digits, e.ovf, e.cyc);
            end
        end
        exp5.delete();
        obs5.delete();
    endtask

    task automatic test_hex;
        logic [15:0] vals[8];
        int acc;
        rec_t e, o;
        vals = '{16'hBEEF, 16'h0000, 16'h1234, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'hA05C};
        for (int i = 4; i < 7; i++) vals[i] = 16'($urandom_range(0, 65535));
        for (int i = 0; i < 8; i++) begin
            send5(vals[i], 1'b0, acc);
            exp5.push_back('{digits: {4'h0, vals[i]}, ovf: 1'b0, cyc: acc + LAT_HEX, blank: 5'b0});
        end
        settle5(8);
        checks++;
        if (obs5.size() != exp5.size()) begin
            errors++;
            $display("FAIL hex_count got %0d results expected %0d", obs5.size(), exp5.size());
        end
        while (exp5.size() > 0 && obs5.size() > 0) begin
            e = exp5.pop_front();
            o = obs5.pop_front();
            checks++;
            if (o.digits !== e.digits || o.ovf !== e.ovf || o.cyc !== e.cyc) begin
                errors++;
                $display("FAIL hex_result got dig=%h ovf=%b cyc=%0d expected dig=%h ovf=%b cyc=%0d",
                         o.digits, o.ovf, o.cyc, e.digits, e.ovf, e.cyc);
            end
        end
        exp5.delete();
        obs5.delete();
        repeat (3) @(negedge clk);
        checks++;
        if (out_digits !== 20'h0A05C || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hex_hold got dig=%h ov=%b expected 0a05c 0", out_digits, out_valid);
        end
    endtask

    task automatic test_digits3;
        logic [15:0] vals[6];
        logic        modes[6];
        int acc;
        rec_t e, o;
        vals  = '{16'd1000, 16'd999, 16'd0, 16'h0ABC, 16'h1234, 16'd65535};
        modes = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            send3(vals[i], modes[i], acc);
            if (modes[i])
                exp3.push_back('{digits: dec_model(int'(vals[i]), 3), ovf: dec_ovf(int'(vals[i]), 3),
                                 cyc: acc + LAT_BCD, blank: 5'b0});
            else
                exp3.push_back('{digits: {8'h00, vals[i][11:0]}, ovf: |vals[i][15:12],
                                 cyc: acc + LAT_HEX, blank: 5'b0});
        end
        settle3(6);
        checks++;
        if (obs3.size() != exp3.size()) begin
            errors++;
            $display("FAIL d3_count got %0d results expected %0d", obs3.size(), exp3.size());
        end
        while (exp3.size() > 0 && obs3.size() > 0) begin
            e = exp3.pop_front();
            o = obs3.pop_front();
            checks++;
            if (o.digits !== e.digits || o.ovf !== e.ovf || o.cyc !== e.cyc) begin
                errors++;
                $display("FAIL d3_result got dig=%h ovf=%b cyc=%0d expected dig=%h ovf=%b cyc=%0d",
                         o.digits, o.ovf, o.cyc, e.digits, e.ovf, e.cyc);
            end
        end
        exp3.delete();
        obs3.delete();
    endtask

    task automatic test_back_to_back;
        int acc1, acc2;
        rec_t e, o;
        acc1 = -1;
        acc2 = -1;
        in_valid = 1'b1;
        in_data  = 16'd12345;
        in_bcd   = 1'b1;
        for (int i = 0; i < 100 && acc1 < 0; i++) begin
            if (in_ready === 1'b1) acc1 = cyc + 1;
            @(negedge clk);
        end
        in_data = 16'd42;
        exp5.push_back('{digits: 20'h12345, ovf: 1'b0, cyc: acc1 + LAT_BCD, blank: 5'b0});
        exp5.push_back('{digits: 20'h00042, ovf: 1'b0, cyc: acc1 + LAT_BCD + 1 + LAT_BCD, blank: 5'b0});
        for (int i = 0; i < 100 && acc2 < 0; i++) begin
            if (in_ready === 1'b1) acc2 = cyc + 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (acc2 !== acc1 + LAT_BCD + 1) begin
            errors++;
            $display("FAIL b2b_accept got cycle %0d expected %0d", acc2, acc1 + LAT_BCD + 1);
        end
        settle5(2);
        checks++;
        if (obs5.size() != exp5.size()) begin
            errors++;
            $display("FAIL b2b_count got %0d results expected %0d", obs5.size(), exp5.size());
        end
        while (exp5.size() > 0 && obs5.size() > 0) begin
            e = exp5.pop_front();
            o = obs5.pop_front();
            checks++;
            if (o.digits !== e.digits || o.ovf !== e.ovf || o.cyc !== e.cyc) begin
                errors++;
                $display("FAIL b2b_result got dig=%h ovf=%b cyc=%0d expected dig=%h ovf=%b cyc=%0d",
                         o.digits, o.ovf, o.cyc, e.digits, e.ovf, e.cyc);
            end
        end
        exp5.delete();
        obs5.delete();
    endtask

    task automatic test_reset_mid;
        int acc;
        rec_t e, o;
        send5(16'd500, 1'b1, acc);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, busy, out_valid, overflow, out_digits} !== {1'b1, 1'b0, 1'b0, 1'b0, 20'h0}) begin
            errors++;
            $display("FAIL midrst_outputs got ready=%b busy=%b ov=%b ovf=%b dig=%h expected 1 0 0 0 00000",
                     in_ready, busy, out_valid, overflow, out_digits);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready got ready=%b busy=%b expected 1 0", in_ready, busy);
        end
        repeat (25) @(negedge clk);
        checks++;
        if (obs5.size() != 0) begin
            errors++;
            $display("FAIL midrst_no_result got %0d results expected 0", obs5.size());
        end
        obs5.delete();
        send5(16'd7, 1'b1, acc);
        exp5.push_back('{digits: 20'h00007, ovf: 1'b0, cyc: acc + LAT_BCD, blank: 5'b0});
        settle5(1);
        checks++;
        if (obs5.size() != exp5.size()) begin
            errors++;
            $display("FAIL midrst_count got %0d results expected %0d", obs5.size(), exp5.size());
        end
        while (exp5.size() > 0 && obs5.size() > 0) begin
            e = exp5.pop_front();
            o = obs5.pop_front();
            checks++;
            if (o.digits !== e.digits || o.ovf !== e.ovf || o.cyc !== e.cyc) begin
                errors++;
                $display("FAIL midrst_result got dig=%h ovf=%b cyc=%0d expected dig=%h ovf=%b cyc=%0d",
                         o.digits, o.ovf, o.cyc, e.digits, e.ovf, e.cyc);
            end
        end
        exp5.delete();
        obs5.delete();
    endtask

`ifdef BIN2DIG_BLANK_EN
    task automatic test_blank;
        int acc;
        rec_t e, o;
        send5(16'd305, 1'b1, acc);
        exp5.push_back('{digits: 20'h00305, ovf: 1'b0, cyc: acc + LAT_BCD, blank: 5'b11000});
        send5(16'd0, 1'b1, acc);
        exp5.push_back('{digits: 20'h00000, ovf: 1'b0, cyc: acc + LAT_BCD, blank: 5'b11110});
        send5(16'h1000, 1'b0, acc);
        exp5.push_back('{digits: 20'h01000, ovf: 1'b0, cyc: acc + LAT_HEX, blank: 5'b10000});
        settle5(3);
        checks++;
        if (obs5.size() != exp5.size()) begin
            errors++;
            $display("FAIL blank_count got %0d results expected %0d", obs5.size(), exp5.size());
        end
        while (exp5.size() > 0 && obs5.size() > 0) begin
            e = exp5.pop_front();
            o = obs5.pop_front();
            checks++;
            if (o.digits !== e.digits || o.blank !== e.blank || o.cyc !== e.cyc) begin
                errors++;
                $display("FAIL blank_result got dig=%h mask=%b cyc=%0d expected dig=%h mask=%b cyc=%0d",
                         o.digits, o.blank, o.cyc, e.digits, e.blank, e.cyc);
            end
        end
        exp5.delete();
        obs5.delete();
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_bcd    = 1'b0;
        in_valid3 = 1'b0;
        in_data3  = '0;
        in_bcd3   = 1'b0;
        test_reset;
        test_bcd;
        test_hex;
        test_digits3;
        test_back_to_back;
        test_reset_mid;
`ifdef BIN2DIG_BLANK_EN
        test_blank;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
